// File: rtl/hd_unload_seq.sv
// rtl/hd_unload_seq.sv - hard-decision unload sequencer for the Lmem unload port
//
// Walks unload addresses 0..UNLOAD_ROWS-1, strobes Lmem once per row, captures
// each Kb*HDWIDTH hard-decision vector into a shift register and streams it out
// as HDWIDTH-bit words, column 0 first, on a valid/ready handshake.
// Optional feature macro: HD_ABORT_EN (adds the abort input).
//
// Ports:
//   clk                 clock, rising edge
//   rst                 synchronous active-low reset
//   abort               (HD_ABORT_EN only) return to IDLE like reset, no done
//   start               begin an unload; ignored unless idle and not in done cycle
//   unload_en           one-cycle Lmem read strobe
//   unloadAddress       Lmem unload row address
//   unload_HDout_vec    Lmem hard-decision vector, held until the next strobe
//   hd_word/hd_valid    output word stream
//   hd_ready            downstream accepts word
//   hd_last             final word of the codeword
//   hd_row/hd_col       row and circulant column of the current word
//   busy                sequence in progress
//   done                one-cycle pulse after the final word is accepted
module hd_unload_seq #(
  parameter int Kb           = 14,
  parameter int HDWIDTH      = 32,
  parameter int ADDRESSWIDTH = 5,
  parameter int UNLOAD_ROWS  = 17,
  parameter int RD_LATENCY   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef HD_ABORT_EN
  input  logic                    abort,
`endif
  input  logic                    start,
  output logic                    unload_en,
  output logic [ADDRESSWIDTH-1:0] unloadAddress,
  input  logic [Kb*HDWIDTH-1:0]   unload_HDout_vec,
  output logic [HDWIDTH-1:0]      hd_word,
  output logic                    hd_valid,
  input  logic                    hd_ready,
  output logic                    hd_last,
  output logic [ADDRESSWIDTH-1:0] hd_row,
  output logic [3:0]              hd_col,
  output logic                    busy,
  output logic                    done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_FLUSH  = 3'd4;

  localparam int LW = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
  localparam logic [LW-1:0]           LP_LAT      = LW'(RD_LATENCY);
  localparam logic [LW-1:0]           LP_LAT_ONE  = LW'(1);
  localparam logic [ADDRESSWIDTH:0]   LP_ROWS     = (ADDRESSWIDTH + 1)'(UNLOAD_ROWS);
  localparam logic [ADDRESSWIDTH:0]   LP_ADDR_ONE = (ADDRESSWIDTH + 1)'(1);
  localparam logic [ADDRESSWIDTH-1:0] LP_LAST_ROW = ADDRESSWIDTH'(UNLOAD_ROWS - 1);
  localparam logic [3:0]              LP_LAST_COL = 4'(Kb - 1);
  localparam logic [3:0]              LP_COL_ONE  = 4'd1;

  logic [2:0]              r_state;
  logic [ADDRESSWIDTH-1:0] r_addr;       // address of the most recent strobe
  logic [ADDRESSWIDTH:0]   r_next_addr;  // one wider so UNLOAD_ROWS itself is representable
  logic [LW-1:0]           r_lat;
  logic [Kb*HDWIDTH-1:0]   r_sr;
  logic                    r_full;
  logic [ADDRESSWIDTH-1:0] r_row;
  logic [3:0]              r_col;
  logic                    r_done;

  logic w_clear;
  logic w_pend;
  logic w_xfer;
  logic w_xfer_end;
  logic w_capture;

`ifdef HD_ABORT_EN
  assign w_clear = !rst || abort;
`else
  assign w_clear = !rst;
`endif

  // A strobed vector is outstanding in ISSUE/WAIT/STREAM; FLUSH means all rows captured.
  assign w_pend     = (r_state == ST_ISSUE) || (r_state == ST_WAIT) || (r_state == ST_STREAM);
  assign w_xfer     = r_full && hd_ready;
  assign w_xfer_end = w_xfer && (r_col == LP_LAST_COL);
  // Lmem holds its output, so the prefetched vector simply waits until the
  // shift register frees up; capture on the same edge as the last word keeps
  // rows back-to-back.
  assign w_capture  = w_pend && (r_lat == '0) && (!r_full || w_xfer_end);

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_next_addr <= '0;
      r_lat       <= '0;
      r_sr        <= '0;
      r_full      <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_lat != '0) begin
        r_lat <= r_lat - LP_LAT_ONE;
      end

      if (w_capture) begin
        r_sr   <= unload_HDout_vec;
        r_full <= 1'b1;
        r_col  <= '0;
        r_row  <= r_addr;
      end else if (w_xfer) begin
        if (r_col == LP_LAST_COL) begin
          r_full <= 1'b0;
        end else begin
          r_sr  <= r_sr >> HDWIDTH;
          r_col <= r_col + LP_COL_ONE;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start && !r_done) begin
            r_state     <= ST_ISSUE;
            r_addr      <= '0;
            r_next_addr <= LP_ADDR_ONE;
            r_lat       <= LP_LAT;
          end
        end
        ST_ISSUE, ST_WAIT, ST_STREAM: begin
          if (w_capture) begin
            if (r_next_addr < LP_ROWS) begin
              // prefetch the next row while this one streams
              r_state     <= ST_ISSUE;
              r_addr      <= r_next_addr[ADDRESSWIDTH-1:0];
              r_next_addr <= r_next_addr + LP_ADDR_ONE;
              r_lat       <= LP_LAT;
            end else begin
              r_state <= ST_FLUSH;
            end
          end else if (r_state == ST_ISSUE || w_xfer_end) begin
            r_state <= (r_full && !w_xfer_end) ? ST_STREAM : ST_WAIT;
          end
        end
        ST_FLUSH: begin
          if (w_xfer_end) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign unload_en     = (r_state == ST_ISSUE);
  assign unloadAddress = r_addr;
  assign hd_word       = r_sr[HDWIDTH-1:0];
  assign hd_valid      = r_full;
  assign hd_last       = r_full && (r_row == LP_LAST_ROW) && (r_col == LP_LAST_COL);
  assign hd_row        = r_row;
  assign hd_col        = r_col;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;

endmodule

// File: tb/tb_hd_unload_seq.sv
// tb/tb_hd_unload_seq.sv - self-checking bench for hd_unload_seq
module tb_hd_unload_seq;
  localparam int KB     = 14;
  localparam int HW     = 32;
  localparam int AW     = 5;
  localparam int NWORDS = KB * 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic hd_ready = 1'b0;
  logic [KB*HW-1:0] vec = '0;
  logic unload_en;
  logic [AW-1:0] unloadAddress;
  logic [HW-1:0] hd_word;
  logic hd_valid, hd_last, busy, done;
  logic [AW-1:0] hd_row;
  logic [3:0] hd_col;
`ifdef HD_ABORT_EN
  logic abort = 1'b0;
`endif

  hd_unload_seq dut (
    .clk(clk),
    .rst(rst),
`ifdef HD_ABORT_EN
    .abort(abort),
`endif
    .start(start),
    .unload_en(unload_en),
    .unloadAddress(unloadAddress),
    .unload_HDout_vec(vec),
    .hd_word(hd_word),
    .hd_valid(hd_valid),
    .hd_ready(hd_ready),
    .hd_last(hd_last),
    .hd_row(hd_row),
    .hd_col(hd_col),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          ue;
    logic [4:0]  addr;
    bit          valid;
    logic [31:0] word;
    bit          last;
    logic [4:0]  row;
    logic [3:0]  col;
    bit          dn;
    bit          bsy;
    bit          cd;
  } exp_t;

  typedef struct {
    bit          ue;
    logic [4:0]  addr;
    bit          valid;
    logic [31:0] word;
    bit          last;
    logic [4:0]  row;
    logic [3:0]  col;
    bit          dn;
    bit          bsy;
  } obs_t;

  typedef struct {
    int         due;
    logic [4:0] a;
  } lm_t;

  exp_t tbl[13];
  obs_t obs[0:2047];
  lm_t  lmq[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc, done_cnt, done_cyc, order_errs, stab_errs, max_out, n_words;
  int ue_in_stall, ue_after;
  bit stall_hit, row4_seen;
  logic [31:0] row4_word;

  function automatic logic [HW-1:0] mkw(input int r, input int k);
    logic [4:0] rr;
    logic [3:0] kk;
    rr = r[4:0];
    kk = k[3:0];
    return {rr, kk, 23'h0};
  endfunction

  function automatic logic [KB*HW-1:0] mkvec(input logic [4:0] a);
    logic [KB*HW-1:0] v;
    v = '0;
    for (int k = 0; k < KB; k++) v[k*HW +: HW] = mkw(int'(a), k);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // mode 0 full rate, 1 backpressure 1,0,0, 2 long stall at row 3 col 13,
  // 3 reset at cycle 100, 4 abort at cycle 50
  task automatic run(input int mode, input int limit);
    obs_t cur, prev;
    bit prev_stall, had_row, r;
    logic [4:0] lrow;
    int strobes, loads, idx, stall_left, ic;
    lm_t e;
    done_cnt = 0; done_cyc = 0; order_errs = 0; stab_errs = 0; max_out = 0;
    n_words = 0; ue_in_stall = 0; ue_after = 0; stall_hit = 0; row4_seen = 0;
    row4_word = '0; prev_stall = 0; had_row = 0; lrow = '0; strobes = 0; loads = 0;
    idx = 0; stall_left = 0; prev = '{default: '0};
    ic = (mode == 3) ? 100 : ((mode == 4) ? 50 : -1);
    lmq.delete();
    cyc = 0;
    start = 1'b1;
    hd_ready = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      rst = 1'b1;
`ifdef HD_ABORT_EN
      abort = 1'b0;
`endif
      cur.ue = unload_en; cur.addr = unloadAddress; cur.valid = hd_valid;
      cur.word = hd_word; cur.last = hd_last; cur.row = hd_row; cur.col = hd_col;
      cur.dn = done; cur.bsy = busy;
      if (cyc < 2048) obs[cyc] = cur;
      // Lmem: data appears RD_LATENCY cycles after the strobe and is held
      if (lmq.size() > 0 && lmq[0].due == cyc) begin
        vec = mkvec(lmq[0].a);
        void'(lmq.pop_front());
      end
      if (cur.ue) begin
        strobes++;
        e.due = cyc + 2;
        e.a = cur.addr;
        lmq.push_back(e);
        if (ic >= 0 && cyc > ic) ue_after++;
      end
      if (cur.dn) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_stall && (!cur.valid || cur.word !== prev.word || cur.row !== prev.row ||
                         cur.col !== prev.col || cur.last !== prev.last))
        stab_errs++;
      if (cur.valid && cur.col == 4'd0 && (!had_row || cur.row != lrow)) begin
        loads++;
        had_row = 1;
        lrow = cur.row;
      end
      if (strobes - loads > max_out) max_out = strobes - loads;
      if (cur.valid) begin
        if (idx >= NWORDS || cur.word !== mkw(idx / KB, idx % KB) ||
            cur.row !== 5'(idx / KB) || cur.col !== 4'(idx % KB) || cur.last !== (idx == NWORDS - 1))
          order_errs++;
      end else if (cur.last) begin
        order_errs++;
      end
      if (mode == 2 && cur.valid && cur.row == 5'd4 && cur.col == 4'd0 && !row4_seen) begin
        row4_seen = 1;
        row4_word = cur.word;
      end
      case (mode)
        1: r = (cyc % 3 == 0);
        2: begin
          if (!stall_hit && cur.valid && cur.row == 5'd3 && cur.col == 4'd13) begin
            stall_hit = 1;
            stall_left = 20;
          end
          r = (stall_left == 0);
          if (stall_left > 0) begin
            if (cur.ue) ue_in_stall++;
            stall_left--;
          end
        end
        default: r = 1'b1;
      endcase
      hd_ready = r;
      if (cur.valid && r) begin
        idx++;
        n_words++;
      end
      prev_stall = cur.valid && !r;
      prev = cur;
      // start while busy and start coincident with done must both be ignored
      if (cyc == 50 || cur.dn) start = 1'b1;
      if (cyc == ic && mode == 3) rst = 1'b0;
`ifdef HD_ABORT_EN
      if (cyc == ic && mode == 4) abort = 1'b1;
`endif
      if (cyc >= limit) break;
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
`ifdef HD_ABORT_EN
    abort = 1'b0;
`endif
    hd_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_table(input string tag);
    obs_t o;
    for (int i = 0; i < 13; i++) begin
      o = obs[tbl[i].cyc];
      chk($sformatf("%s c%0d unload_en", tag, tbl[i].cyc), 32'(o.ue), 32'(tbl[i].ue));
      chk($sformatf("%s c%0d hd_valid", tag, tbl[i].cyc), 32'(o.valid), 32'(tbl[i].valid));
      chk($sformatf("%s c%0d hd_last", tag, tbl[i].cyc), 32'(o.last), 32'(tbl[i].last));
      chk($sformatf("%s c%0d done", tag, tbl[i].cyc), 32'(o.dn), 32'(tbl[i].dn));
      chk($sformatf("%s c%0d busy", tag, tbl[i].cyc), 32'(o.bsy), 32'(tbl[i].bsy));
      if (tbl[i].ue)
        chk($sformatf("%s c%0d unloadAddress", tag, tbl[i].cyc), 32'(o.addr), 32'(tbl[i].addr));
      if (tbl[i].cd) begin
        chk($sformatf("%s c%0d hd_word", tag, tbl[i].cyc), o.word, tbl[i].word);
        chk($sformatf("%s c%0d hd_row", tag, tbl[i].cyc), 32'(o.row), 32'(tbl[i].row));
        chk($sformatf("%s c%0d hd_col", tag, tbl[i].cyc), 32'(o.col), 32'(tbl[i].col));
      end
    end
    chk({tag, " words"}, 32'(n_words), 32'(NWORDS));
    chk({tag, " order_errs"}, 32'(order_errs), 32'd0);
    chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'd242);
    chk({tag, " outstanding_le1"}, 32'(max_out <= 1), 32'd1);
  endtask

  task automatic check_zero(input string tag, input int c);
    obs_t o;
    o = obs[c];
    chk({tag, " unload_en"}, 32'(o.ue), 32'd0);
    chk({tag, " unloadAddress"}, 32'(o.addr), 32'd0);
    chk({tag, " hd_valid"}, 32'(o.valid), 32'd0);
    chk({tag, " hd_word"}, o.word, 32'd0);
    chk({tag, " hd_last"}, 32'(o.last), 32'd0);
    chk({tag, " hd_row"}, 32'(o.row), 32'd0);
    chk({tag, " hd_col"}, 32'(o.col), 32'd0);
    chk({tag, " busy"}, 32'(o.bsy), 32'd0);
    chk({tag, " done"}, 32'(o.dn), 32'd0);
  endtask

  initial begin
    //         cyc  ue addr   valid word        last row    col    dn bsy cd
    tbl[0]  = '{1,   1, 5'd0,  0, 32'h0,       0, 5'd0,  4'd0,  0, 1, 0};
    tbl[1]  = '{2,   0, 5'd0,  0, 32'h0,       0, 5'd0,  4'd0,  0, 1, 0};
    tbl[2]  = '{3,   0, 5'd0,  0, 32'h0,       0, 5'd0,  4'd0,  0, 1, 0};
    tbl[3]  = '{4,   1, 5'd1,  1, mkw(0, 0),   0, 5'd0,  4'd0,  0, 1, 1};
    tbl[4]  = '{5,   0, 5'd0,  1, mkw(0, 1),   0, 5'd0,  4'd1,  0, 1, 1};
    tbl[5]  = '{17,  0, 5'd0,  1, mkw(0, 13),  0, 5'd0,  4'd13, 0, 1, 1};
    tbl[6]  = '{18,  1, 5'd2,  1, mkw(1, 0),   0, 5'd1,  4'd0,  0, 1, 1};
    tbl[7]  = '{19,  0, 5'd0,  1, mkw(1, 1),   0, 5'd1,  4'd1,  0, 1, 1};
    tbl[8]  = '{214, 1, 5'd16, 1, mkw(15, 0),  0, 5'd15, 4'd0,  0, 1, 1};
    tbl[9]  = '{228, 0, 5'd0,  1, mkw(16, 0),  0, 5'd16, 4'd0,  0, 1, 1};
    tbl[10] = '{241, 0, 5'd0,  1, mkw(16, 13), 1, 5'd16, 4'd13, 0, 1, 1};
    tbl[11] = '{242, 0, 5'd0,  0, 32'h0,       0, 5'd0,  4'd0,  1, 0, 0};
    tbl[12] = '{243, 0, 5'd0,  0, 32'h0,       0, 5'd0,  4'd0,  0, 0, 0};

    // reset held for two cycles with start asserted
    rst = 1'b0;
    start = 1'b1;
    hd_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cyc = i;
      obs[0].ue = unload_en; obs[0].addr = unloadAddress; obs[0].valid = hd_valid;
      obs[0].word = hd_word; obs[0].last = hd_last; obs[0].row = hd_row;
      obs[0].col = hd_col; obs[0].dn = done; obs[0].bsy = busy;
      check_zero($sformatf("reset c%0d", i), 0);
    end
    start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset unload_en", 32'(unload_en), 32'd0);
    chk("post_reset busy", 32'(busy), 32'd0);

    run(0, 600);
    check_table("full");

    run(1, 1200);
    chk("bp words", 32'(n_words), 32'(NWORDS));
    chk("bp order_errs", 32'(order_errs), 32'd0);
    chk("bp stable_errs", 32'(stab_errs), 32'd0);
    chk("bp outstanding_le1", 32'(max_out <= 1), 32'd1);
    chk("bp done_count", 32'(done_cnt), 32'd1);

    run(2, 700);
    chk("stall hit", 32'(stall_hit), 32'd1);
    chk("stall ue_during_stall", 32'(ue_in_stall), 32'd0);
    chk("stall row4_seen", 32'(row4_seen), 32'd1);
    chk("stall row4_col0_word", row4_word, mkw(4, 0));
    chk("stall order_errs", 32'(order_errs), 32'd0);
    chk("stall stable_errs", 32'(stab_errs), 32'd0);
    chk("stall words", 32'(n_words), 32'(NWORDS));
    chk("stall done_count", 32'(done_cnt), 32'd1);

    run(3, 400);
    chk("midreset streaming_before", 32'(obs[100].valid), 32'd1);
    check_zero("midreset c101", 101);
    chk("midreset done_count", 32'(done_cnt), 32'd0);
    chk("midreset ue_after", 32'(ue_after), 32'd0);
    chk("midreset order_errs", 32'(order_errs), 32'd0);

    run(0, 600);
    check_table("rerun");

`ifdef HD_ABORT_EN
    run(4, 400);
    chk("abort busy_before", 32'(obs[50].bsy), 32'd1);
    check_zero("abort c51", 51);
    chk("abort done_count", 32'(done_cnt), 32'd0);
    chk("abort ue_after", 32'(ue_after), 32'd0);

    run(0, 600);
    check_table("after_abort");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hd_unload_seq.md
# hd_unload_seq

Hard-decision unload sequencer for the LLR memory (Lmem) unload port. After decoding finishes it walks the unload addresses, pulses `unload_en`/`unloadAddress`, and captures each Kb×HDWIDTH hard-decision vector. It then serializes the vector as HDWIDTH-bit words on a valid/ready stream toward the output interface. It is the reader end of the unload interface, sitting between Lmem and the codeword output FIFO.

## Interface
- `Kb`, 14, systematic circulant columns per unload vector
- `HDWIDTH`, 32, bits per hard-decision word
- `ADDRESSWIDTH`, 5, unload address width
- `UNLOAD_ROWS`, 17, unload addresses issued (0..UNLOAD_ROWS-1)
- `RD_LATENCY`, 2, cycles from `unload_en` to valid `unload_HDout_vec`
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-low reset
- `start` in 1: one-cycle request to begin unload; ignored unless idle
- `unload_en` out 1: one-cycle read strobe to Lmem
- `unloadAddress` out ADDRESSWIDTH: unload row address
- `unload_HDout_vec` in Kb*HDWIDTH: Lmem unload data; held until next strobe
- `hd_word` out HDWIDTH: output word
- `hd_valid` out 1: `hd_word` valid
- `hd_ready` in 1: downstream accepts word
- `hd_last` out 1: marks final word of the codeword
- `hd_row` out ADDRESSWIDTH: row of current word
- `hd_col` out 4: circulant column of current word
- `busy` out 1: sequence in progress
- `done` out 1: one-cycle pulse after final word accepted

## Operation
- States: IDLE, ISSUE, WAIT, STREAM, FLUSH.
  - IDLE→ISSUE on `start`.
  - ISSUE drives `unload_en`=1 for one cycle with the current address.
  - WAIT counts RD_LATENCY cycles, then captures into the shift register.
- Capture rule: capture occurs only when both hold:
  - the latency count has expired;
  - the shift register is empty, or its last word is accepted that cycle.
- Capture actions:
  - load all Kb*HDWIDTH bits;
  - set col=0 and row=address;
  - issue the next address in the following cycle (prefetch).
- Lmem holds its output, so the prefetched vector waits at the Lmem port while streaming stalls; no second internal buffer is needed.
- Word order: row 0 first. Within a row, col k = `unload_HDout_vec[k*HDWIDTH +: HDWIDTH]`, k = 0..Kb-1 ascending.
- Handshake is a transfer when `hd_valid`&&`hd_ready`.
  - On a transfer, advance col. At col=Kb-1 the register becomes empty.
  - While `hd_valid`=1 and `hd_ready`=0, `hd_word`, `hd_row`, `hd_col` and `hd_last` are stable.
  - `hd_valid` never depends combinationally on `hd_ready`.
- `hd_last`=1 only for row UNLOAD_ROWS-1, col Kb-1.
- After the last address is issued, no further `unload_en` is driven. FLUSH drains the remaining words.
- `done` pulses the cycle after the `hd_last` transfer, then the block returns to IDLE with `busy`=0.
- `start` while `busy` is ignored. `start` coincident with `done` is also ignored.

## Timing
- Reset (`rst`=0 at edge): all of the following go to 0 and the state goes to IDLE.
  - `unload_en`, `unloadAddress`, `hd_word`, `hd_valid`
  - `hd_last`, `hd_row`, `hd_col`, `busy`, `done`
- Reset mid-operation aborts immediately: no `done`, and no further `unload_en`.
- `start` sampled at cycle 0 (RD_LATENCY=2):
  - `busy`=1 and `unload_en`=1 with address 0 in cycle 1;
  - capture at the end of cycle 3;
  - `hd_valid`=1 from cycle 4.
- With `hd_ready` held high:
  - one word per cycle, no bubbles between rows;
  - Kb*UNLOAD_ROWS = 238 words, transferred in cycles 4..241;
  - `done` in cycle 242.
- `unload_en` is never asserted while a previously strobed vector is still uncaptured.

## Configuration
- `HD_ABORT_EN`
  - Defined: adds input `abort` (1 bit). `abort`=1 at any edge returns the block to IDLE on that edge with the same output values as reset, and no `done`.
  - Undefined: the port does not exist and the sequence always runs to completion.

## Test plan
- Reset then idle: with `rst`=0 for 2 cycles, all outputs read 0; `start` with `rst`=0 produces no `unload_en`.
- Full-rate unload: Lmem model row r col k = {r[4:0],k[3:0],23'h0}; `hd_ready`=1. Expect:
  - first `hd_valid` at cycle 4, word 0x00000000;
  - word 15 = {5'd1,4'd1,23'h0};
  - `hd_last` at cycle 241 with row 16, col 13;
  - `done` at cycle 242.
- Backpressure: `hd_ready` toggles 1,0,0 repeating. Expect all 238 words in order, each held stable while stalled, and at most one uncaptured outstanding `unload_en`.
- Long stall at row boundary: `hd_ready`=0 for 20 cycles on col 13 of row 3. Expect row 4 col 0 correct after release; no `unload_en` is issued during the stall after the row 4 strobe.
- Reset at cycle 100 mid-stream: outputs zero next cycle, no `done`; a new `start` restarts at address 0.
- With `HD_ABORT_EN`: `abort` at cycle 50 returns to IDLE and suppresses `done`; a subsequent full run matches the full-rate unload results.
